// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes and retire count.
// Optional memory-wait timeout is enabled by defining SEQ_TIMEOUT_EN.
module multicycle_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        reg_we,
    output logic        pc_write,
    output logic [2:0]  state,
    output logic [31:0] instret,
    output logic [1:0]  err_code
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [2:0]  state_q, state_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] instret_q;
    logic        is_legal, is_store, is_load, is_branch;
    logic        timeout;

    // Opcode is decoded live every cycle; nothing about the instruction is latched here.
    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_ALU, OP_ALUI, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: is_legal = 1'b1;
            default:                              is_legal = 1'b0;
        endcase
    end

    assign is_store  = (opcode == OP_STORE);
    assign is_load   = (opcode == OP_LOAD);
    assign is_branch = (opcode == OP_BRANCH);

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] wait_q;

    // Fires on the WAIT_MAX-th consecutive cycle of mem_ready low in FETCH/MEM.
    assign timeout = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready &&
                     (({1'b0, wait_q} + 9'd1) >= 9'(WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 8'd0;
        end else if (state_d != state_q) begin
            wait_q <= 8'd0;
        end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready) begin
            wait_q <= wait_q + 8'd1;
        end
    end
`else
    // Without the timeout option memory waits are unbounded; WAIT_MAX only folds to a constant 0.
    assign timeout = (WAIT_MAX < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = 2'b10;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_SYSTEM) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_HALT;
                    err_d   = 2'b01;
                end
            end
            S_EXEC: begin
                if (is_branch)              state_d = run ? S_FETCH : S_IDLE;
                else if (is_load || is_store) state_d = S_MEM;
                else                        state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_store ? (run ? S_FETCH : S_IDLE) : S_WB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = 2'b10;
                end
            end
            S_WB:   state_d = run ? S_FETCH : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: begin
                state_d = S_HALT;
                err_d   = 2'b01;
            end
        endcase
    end

    // Strobes are decoded from the registered state, so reset forces them low immediately.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_write = 1'b0;
        reg_we   = 1'b0;
        pc_write = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            S_EXEC: pc_write = is_branch;
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_store;
                pc_write = is_store && mem_ready;
            end
            S_WB: begin
                reg_we   = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 32'd0;
        end else if (pc_write) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign state    = state_q;
    assign instret  = instret_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level reference model checked every cycle,
// directed sequences with literal expectations, then randomized instruction streams.
module tb_multicycle_sequencer;

    localparam int WAIT_MAX = 15;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

    localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_ALU   = 7'b0110011, OP_ALUI  = 7'b0010011,
                           OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL   = 7'b1101111, OP_JALR  = 7'b1100111,
                           OP_BR    = 7'b1100011, OP_SYS   = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        mem_req, mem_we, ir_write, reg_we, pc_write;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [1:0]  err_code;

    multicycle_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .reg_we(reg_we),
        .pc_write(pc_write), .state(state), .instret(instret), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current phase of the instruction, error code, retire count.
    logic [2:0]  m_state = IDLE;
    logic [1:0]  m_err = 2'b00;
    logic [31:0] m_instret = 32'd0;
    int          m_wait = 0;

    // Values seen during the most recent step.
    logic [2:0]  o_state;
    logic        o_mem_req, o_mem_we, o_ir_write, o_reg_we, o_pc_write;
    logic [31:0] o_instret;
    logic [1:0]  o_err;

    logic [6:0] legal_ops [9] = '{OP_LOAD, OP_STORE, OP_ALU, OP_ALUI, OP_LUI,
                                  OP_AUIPC, OP_JAL, OP_JALR, OP_BR};

    function automatic bit op_is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic r, input logic rdy, input logic [6:0] op);
        logic       e_req, e_we, e_ir, e_rwe, e_pc;
        logic [2:0] nxt;
        logic       waiting;
        @(negedge clk);
        run = r; mem_ready = rdy; opcode = op;
        #1;
        e_req = (m_state == FETCH) || (m_state == MEM);
        e_we  = (m_state == MEM) && (op == OP_STORE);
        e_ir  = (m_state == FETCH) && rdy;
        e_rwe = (m_state == WB);
        e_pc  = (m_state == WB) || ((m_state == EXEC) && (op == OP_BR)) ||
                ((m_state == MEM) && (op == OP_STORE) && rdy);
        check("state", 32'(state), 32'(m_state));
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("ir_write", 32'(ir_write), 32'(e_ir));
        check("reg_we", 32'(reg_we), 32'(e_rwe));
        check("pc_write", 32'(pc_write), 32'(e_pc));
        check("instret", instret, m_instret);
        check("err_code", 32'(err_code), 32'(m_err));
        o_state = state; o_mem_req = mem_req; o_mem_we = mem_we; o_ir_write = ir_write;
        o_reg_we = reg_we; o_pc_write = pc_write; o_instret = instret; o_err = err_code;

        if (e_pc) m_instret = m_instret + 32'd1;
        nxt = m_state;
        case (m_state)
            IDLE:   nxt = r ? FETCH : IDLE;
            FETCH:  if (rdy) nxt = DECODE;
            DECODE: begin
                if (op_is_legal(op)) nxt = EXEC;
                else begin
                    nxt = HALT;
                    if (op != OP_SYS) m_err = 2'b01;
                end
            end
            EXEC: begin
                if (op == OP_BR) nxt = r ? FETCH : IDLE;
                else if (op == OP_LOAD || op == OP_STORE) nxt = MEM;
                else nxt = WB;
            end
            MEM:    if (rdy) nxt = (op == OP_STORE) ? (r ? FETCH : IDLE) : WB;
            WB:     nxt = r ? FETCH : IDLE;
            default: nxt = HALT;
        endcase
        waiting = ((m_state == FETCH) || (m_state == MEM)) && !rdy;
`ifdef SEQ_TIMEOUT_EN
        if (waiting && (m_wait + 1 >= WAIT_MAX)) begin
            nxt = HALT;
            m_err = 2'b10;
        end
`endif
        if (nxt != m_state) m_wait = 0;
        else if (waiting) m_wait = m_wait + 1;
        m_state = nxt;
    endtask

    task automatic model_reset();
        m_state = IDLE; m_err = 2'b00; m_instret = 32'd0; m_wait = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0; mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_strobes", {27'd0, mem_req, mem_we, ir_write, reg_we, pc_write}, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycles from one FETCH entry to the next with memory always ready.
    task automatic measure(input logic [6:0] op, output int lat);
        do_reset();
        step(1'b1, 1'b1, op);
        step(1'b1, 1'b1, op);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, op);
            lat++;
            if (o_state == FETCH) break;
        end
    endtask

    task automatic run_directed();
        int lat;
        int mem_cycles;

        // ALU instruction: 1,2,3,5,1 with reg_we/pc_write only in WB.
        do_reset();
        step(1'b1, 1'b1, OP_ALU);  check("alu_idle", 32'(o_state), 32'd0);
        step(1'b1, 1'b1, OP_ALU);  check("alu_fetch", 32'(o_state), 32'd1);
        check("alu_ir_write", 32'(o_ir_write), 32'd1);
        step(1'b1, 1'b1, OP_ALU);  check("alu_decode", 32'(o_state), 32'd2);
        step(1'b1, 1'b1, OP_ALU);  check("alu_exec", 32'(o_state), 32'd3);
        check("alu_exec_pc", 32'(o_pc_write), 32'd0);
        step(1'b1, 1'b1, OP_ALU);  check("alu_wb", 32'(o_state), 32'd5);
        check("alu_wb_strobes", {30'd0, o_reg_we, o_pc_write}, 32'd3);
        step(1'b1, 1'b1, OP_ALU);  check("alu_refetch", 32'(o_state), 32'd1);
        check("alu_instret", o_instret, 32'd1);

        measure(OP_BR, lat);    check("lat_branch", 32'(lat), 32'd3);
        measure(OP_STORE, lat); check("lat_store", 32'(lat), 32'd4);
        measure(OP_JAL, lat);   check("lat_jal", 32'(lat), 32'd4);
        measure(OP_LOAD, lat);  check("lat_load", 32'(lat), 32'd5);

        // Load with three wait cycles in MEM.
        do_reset();
        step(1'b1, 1'b1, OP_LOAD);
        step(1'b1, 1'b1, OP_LOAD);
        step(1'b1, 1'b1, OP_LOAD);
        step(1'b1, 1'b1, OP_LOAD);
        mem_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 3), OP_LOAD);
            if (o_state == MEM && o_mem_req && !o_mem_we) mem_cycles++;
        end
        check("load_mem_cycles", 32'(mem_cycles), 32'd4);
        step(1'b1, 1'b1, OP_LOAD); check("load_wb", 32'(o_state), 32'd5);
        step(1'b1, 1'b1, OP_LOAD); check("load_instret", o_instret, 32'd1);

        // Store: write strobe and retire on the mem_ready cycle, no register write.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, OP_STORE);
        step(1'b1, 1'b1, OP_STORE);
        check("store_mem", 32'(o_state), 32'd4);
        check("store_strobes", {29'd0, o_mem_we, o_pc_write, o_reg_we}, 32'd6);
        step(1'b1, 1'b1, OP_STORE); check("store_next", 32'(o_state), 32'd1);
        check("store_instret", o_instret, 32'd1);

        // Branch retires from EXEC and never visits MEM/WB.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, OP_BR);
        step(1'b1, 1'b1, OP_BR);
        check("br_exec_pc", {29'd0, o_state}, 32'd3);
        check("br_exec_pc_write", 32'(o_pc_write), 32'd1);
        step(1'b0, 1'b1, OP_BR); check("br_next", 32'(o_state), 32'd1);

        // Illegal opcode halts with err 01 until reset.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7'b0000000);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 7'b0000000);
        check("ill_halt", 32'(o_state), 32'd6);
        check("ill_err", 32'(o_err), 32'd1);
        check("ill_instret", o_instret, 32'd0);

        // System opcode halts without an error code.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, OP_SYS);
        check("sys_halt", 32'(o_state), 32'd6);
        check("sys_err", 32'(o_err), 32'd0);

        // Memory never ready in FETCH.
        do_reset();
        step(1'b1, 1'b0, OP_ALU);
        for (int i = 0; i < WAIT_MAX; i++) step(1'b1, 1'b0, OP_ALU);
        check("to_last_wait", 32'(o_state), 32'd1);
        step(1'b1, 1'b0, OP_ALU);
`ifdef SEQ_TIMEOUT_EN
        check("to_state", 32'(o_state), 32'd6);
        check("to_err", 32'(o_err), 32'd2);
`else
        check("to_state", 32'(o_state), 32'd1);
        check("to_err", 32'(o_err), 32'd0);
`endif
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, OP_ALU);

        // Retire count wraps from all-ones to zero.
        do_reset();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, OP_ALUI);
        step(1'b1, 1'b1, OP_ALUI);
        check("wrap_instret", o_instret, 32'd0);

        // Reset while a store is completing in MEM drops everything at once.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, OP_STORE);
        @(negedge clk);
        mem_ready = 1'b1; opcode = OP_STORE;
        #1;
        check("mid_mem_req", 32'(mem_req), 32'd1);
        check("mid_mem_pc", 32'(pc_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_pc", 32'(pc_write), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        model_reset();
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_random();
        logic [6:0] op;
        int         halt_cycles;
        int         pick;
        op = OP_ALU;
        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_state == HALT) halt_cycles++;
            if (halt_cycles > 2 || $urandom_range(0, 299) == 0) begin
                do_reset();
                halt_cycles = 0;
            end
            if (m_state == IDLE || m_state == FETCH) begin
                pick = int'($urandom_range(0, 99));
                if (pick < 90) op = legal_ops[$urandom_range(0, 8)];
                else if (pick < 93) op = OP_SYS;
                else op = 7'($urandom_range(0, 127));
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, op);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        run_directed();
        run_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
